ic_bd_transpose_pingpong: RTL and testbench

//  Parametrised ping-pong transpose buffer for the separable 2-D BinDCT datapath.
//  - Sits between the first 1-D stage (produces rows) and the second 1-D stage
//    (consumes columns).
//  - Replaces the fixed 8x8 dual-buffer/mux/control arrangement.
//  - Adds generic block size and element width, a row/column mode, downstream

---
 rtl/ic_bd_transpose_pingpong_if.sv | 24 ++
 rtl/ic_bd_transpose_pingpong.sv | 109 ++++++++++
 tb/tb_ic_bd_transpose_pingpong.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ic_bd_transpose_pingpong_if.sv
// Row-in / vector-out handshake bundle for the BinDCT ping-pong transpose buffer.
// The upstream/downstream side drives through master; the buffer sits on slave.
interface ic_bd_transpose_pingpong_if #(
  parameter int N = 8,
  parameter int W = 12
);
  logic           inputready;
  logic [N*W-1:0] x;
  logic           in_ack;
  logic           outputready;
  logic [N*W-1:0] y;
  logic           out_ack;
  logic           overflow;

  modport master (
    output inputready, x, out_ack,
    input  in_ack, outputready, y, overflow
  );

  modport slave (
    input  inputready, x, out_ack,
    output in_ack, outputready, y, overflow
  );
endinterface

// File: rtl/ic_bd_transpose_pingpong.sv
// Ping-pong transpose buffer between the row and column 1-D BinDCT stages:
// one bank fills with rows while the other drains as columns (or rows when MODE=0).
module ic_bd_transpose_pingpong #(
  parameter int N    = 8,
  parameter int W    = 12,
  parameter int MODE = 1
) (
  input  logic clk,
  input  logic reset,
  ic_bd_transpose_pingpong_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef logic [W-1:0] word_t;

  word_t            mem_q [2][N][N];
  logic             wb_q, wb_d, rb_q, rb_d;
  logic [1:0]       full_q, full_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             outputready_q, outputready_d;
  logic [N*W-1:0]   y_q, y_d, rd_vec;
  logic             overflow_q, overflow_d;
  logic             in_ack, accept, load;

  // Per-output-word read select: column walk in transpose mode, row walk otherwise.
  for (genvar r = 0; r < N; r++) begin : g_rd
    if (MODE == 1) begin : g_col
      assign rd_vec[r*W +: W] = mem_q[rb_q][r][rd_cnt_q];
    end else begin : g_row
      assign rd_vec[r*W +: W] = mem_q[rb_q][rd_cnt_q][r];
    end
  end

  always_comb begin
    in_ack        = !full_q[wb_q];
    accept        = bus.inputready & in_ack;
    load          = full_q[rb_q] & (!outputready_q | bus.out_ack);
    wb_d          = wb_q;
    rb_d          = rb_q;
    full_d        = full_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    outputready_d = outputready_q;
    y_d           = y_q;
    overflow_d    = overflow_q;

    if (bus.inputready && !in_ack) overflow_d = 1'b1;

    if (accept) begin
      if (wr_cnt_q == LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_cnt_d     = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end

    // Write side only ever targets a non-full bank, so the two flag updates never collide.
    if (load) begin
      y_d           = rd_vec;
      outputready_d = 1'b1;
      if (rd_cnt_q == LAST) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rd_cnt_d     = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + CW'(1);
      end
    end else if (bus.out_ack) begin
      outputready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q          <= 1'b0;
      rb_q          <= 1'b0;
      full_q        <= 2'b00;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      outputready_q <= 1'b0;
      y_q           <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wb_q          <= wb_d;
      rb_q          <= rb_d;
      full_q        <= full_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      outputready_q <= outputready_d;
      y_q           <= y_d;
      overflow_q    <= overflow_d;
    end
  end

  // Bank storage is never cleared; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < N; c++) mem_q[wb_q][wr_cnt_q][c] <= bus.x[c*W +: W];
    end
  end

  assign bus.in_ack      = in_ack;
  assign bus.outputready = outputready_q;
  assign bus.y           = y_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ic_bd_transpose_pingpong.sv
// Drives a transpose (MODE=1) and a pass-through (MODE=0) instance with identical
// stimulus and checks both against a bank-count reference model and per-mode scoreboards.
module tb_ic_bd_transpose_pingpong;
  localparam int N  = 8;
  localparam int W  = 12;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          reset, inputready, out_ack;
  logic [VW-1:0] x;
  int            total = 0, bad = 0;
  bit            mon_en = 1'b0;

  always #5 clk = ~clk;

  ic_bd_transpose_pingpong_if #(.N(N), .W(W)) bus1 ();
  ic_bd_transpose_pingpong_if #(.N(N), .W(W)) bus0 ();

  assign bus1.inputready = inputready;
  assign bus1.x          = x;
  assign bus1.out_ack    = out_ack;
  assign bus0.inputready = inputready;
  assign bus0.x          = x;
  assign bus0.out_ack    = out_ack;

  ic_bd_transpose_pingpong #(.N(N), .W(W), .MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  ic_bd_transpose_pingpong #(.N(N), .W(W), .MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  // Reference model: number of full banks, fill/drain counters, expected vectors.
  int            m_nfull, m_wr, m_rd;
  bit            m_ordy, m_ovf;
  logic [VW-1:0] mrows [N];
  logic [VW-1:0] q1 [$];
  logic [VW-1:0] q0 [$];

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_nfull = 0; m_wr = 0; m_rd = 0; m_ordy = 0; m_ovf = 0;
      q1.delete(); q0.delete();
    end else begin
      bit ld, acc_ok;
      int d;
      logic [VW-1:0] v;
      acc_ok = (m_nfull != 2);
      ld     = (m_nfull > 0) && (!m_ordy || out_ack);
      d      = 0;
      if (inputready && acc_ok) begin
        mrows[m_wr] = x;
        if (m_wr == N - 1) begin
          for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) v[r*W +: W] = mrows[r][c*W +: W];
            q1.push_back(v);
          end
          for (int r = 0; r < N; r++) q0.push_back(mrows[r]);
          m_wr = 0;
          d++;
        end else m_wr++;
      end else if (inputready) m_ovf = 1;
      if (ld) begin
        m_ordy = 1;
        if (m_rd == N - 1) begin m_rd = 0; d--; end
        else m_rd++;
      end else if (out_ack) m_ordy = 0;
      m_nfull += d;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ack1", VW'(bus1.in_ack), VW'(m_nfull != 2));
      chk("in_ack0", VW'(bus0.in_ack), VW'(m_nfull != 2));
      chk("ordy1", VW'(bus1.outputready), VW'(m_ordy));
      chk("ordy0", VW'(bus0.outputready), VW'(m_ordy));
      chk("ovf1", VW'(bus1.overflow), VW'(m_ovf));
      chk("ovf0", VW'(bus0.overflow), VW'(m_ovf));
      if (bus1.outputready) begin
        if (q1.size() == 0) chk("q1_avail", VW'(q1.size()), VW'(1));
        else begin
          chk("y1", bus1.y, q1[0]);
          if (out_ack) void'(q1.pop_front());
        end
      end
      if (bus0.outputready) begin
        if (q0.size() == 0) chk("q0_avail", VW'(q0.size()), VW'(1));
        else begin
          chk("y0", bus0.y, q0[0]);
          if (out_ack) void'(q0.pop_front());
        end
      end
    end
  end

  // kind 0: 16r+c, kind 1: random, kind 2: mix of -2048 / 2047 / random
  function automatic logic [VW-1:0] mk_row(input int kind, input int r);
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) begin
      case (kind)
        0:       v[c*W +: W] = W'(16 * r + c);
        1:       v[c*W +: W] = W'($urandom);
        default: v[c*W +: W] = ((c + r) % 3 == 0) ? 12'h800 :
                               ((c + r) % 3 == 1) ? 12'h7FF : W'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic send_row(input logic [VW-1:0] r);
    inputready = 1'b1;
    x          = r;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int i;
    inputready = 1'b0;
    out_ack    = 1'b1;
    i = 0;
    while (i < 100 && (q1.size() != 0 || q0.size() != 0 || m_nfull != 0)) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_left", VW'(q1.size() + q0.size()), VW'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; inputready = 1'b0; out_ack = 1'b1; x = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ordy", VW'(bus1.outputready), VW'(0));
    chk("rst_y", bus1.y, VW'(0));
    chk("rst_in_ack", VW'(bus1.in_ack), VW'(1));
    chk("rst_ovf", VW'(bus1.overflow), VW'(0));
    reset  = 1'b0;
    mon_en = 1'b1;

    // one block, latency of the first column
    for (int r = 0; r < N; r++) send_row(mk_row(0, r));
    chk("lat_pre", VW'(bus1.outputready), VW'(0));
    inputready = 1'b0;
    @(posedge clk); #1;
    chk("lat_first", VW'(bus1.outputready), VW'(1));
    drain();

    // four back-to-back blocks at full rate
    for (int i = 0; i < 4 * N; i++) send_row(mk_row(1, i % N));
    inputready = 1'b0;
    chk("b2b_ovf", VW'(bus1.overflow), VW'(0));
    drain();

    // downstream stalled: both banks fill, 17th row dropped
    out_ack = 1'b0;
    for (int i = 0; i < 2 * N + 1; i++) send_row(mk_row(1, i % N));
    inputready = 1'b0;
    chk("stall_in_ack", VW'(bus1.in_ack), VW'(0));
    chk("stall_ovf", VW'(bus1.overflow), VW'(1));
    repeat (3) begin @(posedge clk); #1; end
    drain();

    // extremes with random back-pressure
    for (int i = 0; i < 2 * N; i++) begin
      out_ack = 1'($urandom_range(0, 1));
      send_row(mk_row(2, i % N));
    end
    drain();

    // reset after 5 rows, then a clean block
    for (int r = 0; r < 5; r++) send_row(mk_row(1, r));
    inputready = 1'b0;
    reset      = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ordy", VW'(bus1.outputready), VW'(0));
    chk("mid_rst_y", bus1.y, VW'(0));
    chk("mid_rst_in_ack", VW'(bus1.in_ack), VW'(1));
    chk("mid_rst_y0", bus0.y, VW'(0));
    reset = 1'b0;
    for (int r = 0; r < N; r++) send_row(mk_row(0, r));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
